// File: rtl/axil2wbsp_rr_if.sv
// Bus bundle for the AXI-lite to Wishbone bridge.
// Holds the AXI-lite slave channels (AW, W, B, AR, R) and the pipelined
// Wishbone master signals. Signal names keep their bridge-relative prefixes:
// i_* is driven into the bridge and o_* is driven by the bridge.
//   slave  : the bridge's view (AXI-lite slave port, Wishbone master port)
//   master : the environment's view (AXI-lite master, Wishbone peripheral)
interface axil2wbsp_rr_if #(
  parameter int DW     = 32,
  parameter int AXI_AW = 28,
  parameter int WB_AW  = AXI_AW - $clog2(DW/8)
);
  logic              i_axi_awvalid;
  logic              o_axi_awready;
  logic [AXI_AW-1:0] i_axi_awaddr;
  logic [2:0]        i_axi_awprot;
  logic              i_axi_wvalid;
  logic              o_axi_wready;
  logic [DW-1:0]     i_axi_wdata;
  logic [DW/8-1:0]   i_axi_wstrb;
  logic              o_axi_bvalid;
  logic              i_axi_bready;
  logic [1:0]        o_axi_bresp;
  logic              i_axi_arvalid;
  logic              o_axi_arready;
  logic [AXI_AW-1:0] i_axi_araddr;
  logic [2:0]        i_axi_arprot;
  logic              o_axi_rvalid;
  logic              i_axi_rready;
  logic [DW-1:0]     o_axi_rdata;
  logic [1:0]        o_axi_rresp;

  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_we;
  logic [WB_AW-1:0]  o_wb_addr;
  logic [DW-1:0]     o_wb_data;
  logic [DW/8-1:0]   o_wb_sel;
  logic              i_wb_stall;
  logic              i_wb_ack;
  logic              i_wb_err;
  logic [DW-1:0]     i_wb_data;

  modport slave (
    input  i_axi_awvalid, i_axi_awaddr, i_axi_awprot,
    input  i_axi_wvalid, i_axi_wdata, i_axi_wstrb, i_axi_bready,
    input  i_axi_arvalid, i_axi_araddr, i_axi_arprot, i_axi_rready,
    output o_axi_awready, o_axi_wready, o_axi_bvalid, o_axi_bresp,
    output o_axi_arready, o_axi_rvalid, o_axi_rdata, o_axi_rresp,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
  );

  modport master (
    output i_axi_awvalid, i_axi_awaddr, i_axi_awprot,
    output i_axi_wvalid, i_axi_wdata, i_axi_wstrb, i_axi_bready,
    output i_axi_arvalid, i_axi_araddr, i_axi_arprot, i_axi_rready,
    input  o_axi_awready, o_axi_wready, o_axi_bvalid, o_axi_bresp,
    input  o_axi_arready, o_axi_rvalid, o_axi_rdata, o_axi_rresp,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
  );
endinterface

// File: rtl/axil2wbsp_rr.sv
// Serialising AXI-lite slave to pipelined Wishbone master bridge with an
// internal read/write arbiter, a Wishbone response timeout, and distinct AXI
// responses for WB err (SLVERR) and timeout / disabled direction (DECERR).
// One transaction is in flight at a time.
// Ports:
//   i_clk   : system clock
//   i_reset : synchronous active-high reset
//   bus     : axil2wbsp_rr_if.slave -- AXI-lite AW/W/B/AR/R channels and
//             Wishbone cyc/stb/we/addr/data/sel/stall/ack/err/data
// OPT_READONLY and OPT_WRITEONLY must not both be set.
module axil2wbsp_rr #(
  parameter int         C_AXI_DATA_WIDTH = 32,
  parameter int         C_AXI_ADDR_WIDTH = 28,
  parameter logic [1:0] OPT_ARB          = 2'b00,
  parameter int         TIMEOUT          = 1024,
  parameter bit         OPT_READONLY     = 1'b0,
  parameter bit         OPT_WRITEONLY    = 1'b0
) (
  input logic           i_clk,
  input logic           i_reset,
  axil2wbsp_rr_if.slave bus
);
  localparam int DW  = C_AXI_DATA_WIDTH;
  localparam int LSB = $clog2(DW/8);
  localparam int AW  = C_AXI_ADDR_WIDTH - LSB;
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]      state_q, state_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d, rdata_q, rdata_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic [1:0]      resp_q, resp_d;
  logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            rd_next_q, rd_next_d;

  logic wr_req, rd_req, pick_rd, grant_wr, grant_rd, wb_done, timed_out;

  // Protection bits carry no meaning here; address bits are consumed below.
  logic unused_inputs;
  assign unused_inputs = ^{bus.i_axi_awprot, bus.i_axi_arprot,
                           bus.i_axi_awaddr, bus.i_axi_araddr};

  always_comb begin
    wr_req = bus.i_axi_awvalid && bus.i_axi_wvalid;
    rd_req = bus.i_axi_arvalid;
    case (OPT_ARB)
      2'b01:   pick_rd = 1'b1;
      2'b10:   pick_rd = 1'b0;
      default: pick_rd = rd_next_q;
    endcase
    grant_rd  = (state_q == S_IDLE) && rd_req && (!wr_req || pick_rd);
    grant_wr  = (state_q == S_IDLE) && wr_req && (!rd_req || !pick_rd);
    wb_done   = cyc_q && (bus.i_wb_ack || bus.i_wb_err);
    timed_out = (TIMEOUT != 0) && cyc_q && !wb_done && (tcnt_q == TLAST);
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    tcnt_d    = tcnt_q;
    rd_next_d = rd_next_q;
    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (grant_wr || grant_rd) begin
          // Serving a write makes a read the preferred next grant and vice versa.
          rd_next_d = grant_wr;
          we_d      = grant_wr;
          addr_d    = grant_wr ? bus.i_axi_awaddr[C_AXI_ADDR_WIDTH-1:LSB]
                               : bus.i_axi_araddr[C_AXI_ADDR_WIDTH-1:LSB];
          data_d    = bus.i_axi_wdata;
          sel_d     = grant_wr ? bus.i_axi_wstrb : '1;
          if ((grant_wr && OPT_READONLY) || (grant_rd && OPT_WRITEONLY)) begin
            // Disabled direction: answer immediately without touching the bus.
            state_d  = S_RESP;
            resp_d   = RESP_DECERR;
            rdata_d  = '0;
            bvalid_d = grant_wr;
            rvalid_d = grant_rd;
          end else begin
            state_d = S_REQ;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
          end
        end
      end
      S_REQ, S_WAIT: begin
        if (wb_done || timed_out) begin
          state_d  = S_RESP;
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          tcnt_d   = '0;
          bvalid_d = we_q;
          rvalid_d = !we_q;
          // err outranks ack; anything else reaching here is a timeout.
          if (wb_done) resp_d = bus.i_wb_err ? RESP_SLVERR : RESP_OKAY;
          else         resp_d = RESP_DECERR;
          rdata_d = (wb_done && !bus.i_wb_err && !we_q) ? bus.i_wb_data : '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if ((state_q == S_REQ) && !bus.i_wb_stall) begin
            stb_d   = 1'b0;
            state_d = S_WAIT;
          end
        end
      end
      default: begin
        if ((bvalid_q && bus.i_axi_bready) || (rvalid_q && bus.i_axi_rready)) begin
          state_d  = S_IDLE;
          bvalid_d = 1'b0;
          rvalid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      tcnt_q    <= '0;
      rd_next_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      tcnt_q    <= tcnt_d;
      rd_next_q <= rd_next_d;
    end
  end

  assign bus.o_axi_awready = grant_wr;
  assign bus.o_axi_wready  = grant_wr;
  assign bus.o_axi_arready = grant_rd;
  assign bus.o_axi_bvalid  = bvalid_q;
  assign bus.o_axi_bresp   = resp_q;
  assign bus.o_axi_rvalid  = rvalid_q;
  assign bus.o_axi_rdata   = rdata_q;
  assign bus.o_axi_rresp   = resp_q;
  assign bus.o_wb_cyc      = cyc_q;
  assign bus.o_wb_stb      = stb_q;
  assign bus.o_wb_we       = we_q;
  assign bus.o_wb_addr     = addr_q;
  assign bus.o_wb_data     = data_q;
  assign bus.o_wb_sel      = sel_q;
endmodule

// File: tb/tb_axil2wbsp_rr.sv
// Scoreboard bench for axil2wbsp_rr. dut_a: round-robin, TIMEOUT=8.
// dut_b: write priority, read-only, TIMEOUT=8.
module tb_axil2wbsp_rr;
  localparam int DW = 32;
  localparam int AXI_AW = 28;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil2wbsp_rr_if #(.DW(DW), .AXI_AW(AXI_AW)) bus_a ();
  axil2wbsp_rr_if #(.DW(DW), .AXI_AW(AXI_AW)) bus_b ();

  axil2wbsp_rr #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AXI_AW), .OPT_ARB(2'b00),
                 .TIMEOUT(8), .OPT_READONLY(1'b0), .OPT_WRITEONLY(1'b0))
    dut_a (.i_clk(clk), .i_reset(rst), .bus(bus_a));

  axil2wbsp_rr #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AXI_AW), .OPT_ARB(2'b10),
                 .TIMEOUT(8), .OPT_READONLY(1'b1), .OPT_WRITEONLY(1'b0))
    dut_b (.i_clk(clk), .i_reset(rst), .bus(bus_b));

  typedef struct packed {
    logic        is_wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int checks = 0;
  int errors = 0;

  // WB slave controls for dut_a (written only by the main process)
  int          a_stall_cfg = 0;
  bit          a_noack = 1'b0;
  bit          a_err = 1'b0;
  logic [31:0] a_rdata = 32'h0;
  bit          b_cyc_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int which, input logic is_wr, input logic [1:0] resp,
                      input logic [31:0] rdata);
    exp_t e;
    e.is_wr = is_wr;
    e.resp  = resp;
    e.rdata = rdata;
    if (which == 0) sb_a.push_back(e);
    else            sb_b.push_back(e);
  endtask

  // Monitors: pop one expectation per completed B or R handshake.
  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus_a.o_axi_bvalid && bus_a.i_axi_bready) begin
        if (sb_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_b: got bresp 0x%0h, want no response", bus_a.o_axi_bresp);
        end else begin
          e = sb_a.pop_front();
          chk("a_b_kind", 32'(1'b1), 32'(e.is_wr));
          chk("a_bresp", 32'(bus_a.o_axi_bresp), 32'(e.resp));
        end
      end
      if (!rst && bus_a.o_axi_rvalid && bus_a.i_axi_rready) begin
        if (sb_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_r: got rdata 0x%0h, want no response", bus_a.o_axi_rdata);
        end else begin
          e = sb_a.pop_front();
          chk("a_r_kind", 32'(1'b0), 32'(e.is_wr));
          chk("a_rresp", 32'(bus_a.o_axi_rresp), 32'(e.resp));
          chk("a_rdata", bus_a.o_axi_rdata, e.rdata);
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus_b.o_axi_bvalid && bus_b.i_axi_bready) begin
        if (sb_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_b: got bresp 0x%0h, want no response", bus_b.o_axi_bresp);
        end else begin
          e = sb_b.pop_front();
          chk("b_b_kind", 32'(1'b1), 32'(e.is_wr));
          chk("b_bresp", 32'(bus_b.o_axi_bresp), 32'(e.resp));
        end
      end
      if (!rst && bus_b.o_axi_rvalid && bus_b.i_axi_rready) begin
        if (sb_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_r: got rdata 0x%0h, want no response", bus_b.o_axi_rdata);
        end else begin
          e = sb_b.pop_front();
          chk("b_r_kind", 32'(1'b0), 32'(e.is_wr));
          chk("b_rresp", 32'(bus_b.o_axi_rresp), 32'(e.resp));
          chk("b_rdata", bus_b.o_axi_rdata, e.rdata);
        end
      end
    end
  end

  // WB peripheral for dut_a: optional stall, ack/err one cycle after stb accepted.
  initial begin : wb_slave_a
    bit acc = 1'b0;
    bit in_req = 1'b0;
    int left = 0;
    bus_a.i_wb_stall = 1'b0; bus_a.i_wb_ack = 1'b0;
    bus_a.i_wb_err = 1'b0;   bus_a.i_wb_data = '0;
    forever begin
      @(posedge clk); #1;
      bus_a.i_wb_ack = 1'b0; bus_a.i_wb_err = 1'b0; bus_a.i_wb_stall = 1'b0;
      if (acc && !a_noack && bus_a.o_wb_cyc) begin
        if (a_err) bus_a.i_wb_err = 1'b1;
        else begin bus_a.i_wb_ack = 1'b1; bus_a.i_wb_data = a_rdata; end
      end
      acc = 1'b0;
      if (!bus_a.o_wb_cyc) in_req = 1'b0;
      if (bus_a.o_wb_cyc && bus_a.o_wb_stb) begin
        if (!in_req) begin in_req = 1'b1; left = a_stall_cfg; end
        if (left > 0) begin bus_a.i_wb_stall = 1'b1; left--; end
        else begin acc = 1'b1; in_req = 1'b0; end
      end
    end
  end

  initial begin : wb_slave_b
    bit acc = 1'b0;
    bus_b.i_wb_stall = 1'b0; bus_b.i_wb_ack = 1'b0;
    bus_b.i_wb_err = 1'b0;   bus_b.i_wb_data = '0;
    forever begin
      @(posedge clk); #1;
      bus_b.i_wb_ack = 1'b0;
      if (acc && bus_b.o_wb_cyc) begin
        bus_b.i_wb_ack = 1'b1; bus_b.i_wb_data = 32'h0BAD_F00D;
      end
      acc = bus_b.o_wb_cyc && bus_b.o_wb_stb;
    end
  end

  initial begin : cyc_watch_b
    forever begin
      @(negedge clk);
      if (bus_b.o_wb_cyc) b_cyc_seen = 1'b1;
    end
  end

  task automatic a_write(input logic [27:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    bus_a.i_axi_awaddr = addr; bus_a.i_axi_wdata = data; bus_a.i_axi_wstrb = strb;
    bus_a.i_axi_awvalid = 1'b1; bus_a.i_axi_wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus_a.o_axi_awready && n < 100);
    if (!bus_a.o_axi_awready) begin
      checks++; errors++;
      $display("FAIL a_write_accept: got no awready in %0d cycles, want awready", n);
    end
    @(posedge clk); #1;
    bus_a.i_axi_awvalid = 1'b0; bus_a.i_axi_wvalid = 1'b0;
  endtask

  task automatic a_read(input logic [27:0] addr);
    int n = 0;
    bus_a.i_axi_araddr = addr; bus_a.i_axi_arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus_a.o_axi_arready && n < 100);
    if (!bus_a.o_axi_arready) begin
      checks++; errors++;
      $display("FAIL a_read_accept: got no arready in %0d cycles, want arready", n);
    end
    @(posedge clk); #1;
    bus_a.i_axi_arvalid = 1'b0;
  endtask

  task automatic wait_sb(input int which);
    int n = 0;
    while (((which == 0) ? sb_a.size() : sb_b.size()) != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    if (((which == 0) ? sb_a.size() : sb_b.size()) != 0) begin
      checks++; errors++;
      $display("FAIL wait_resp_%0d: got %0d pending responses, want 0", which,
               (which == 0) ? sb_a.size() : sb_b.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, nr, nw, ncnt;
    bit ok;
    string order, exp_order;

    rst = 1'b1;
    bus_a.i_axi_awvalid = 1'b0; bus_a.i_axi_awaddr = '0; bus_a.i_axi_awprot = '0;
    bus_a.i_axi_wvalid = 1'b0;  bus_a.i_axi_wdata = '0;  bus_a.i_axi_wstrb = '0;
    bus_a.i_axi_bready = 1'b1;  bus_a.i_axi_arvalid = 1'b0; bus_a.i_axi_araddr = '0;
    bus_a.i_axi_arprot = '0;    bus_a.i_axi_rready = 1'b1;
    bus_b.i_axi_awvalid = 1'b0; bus_b.i_axi_awaddr = '0; bus_b.i_axi_awprot = '0;
    bus_b.i_axi_wvalid = 1'b0;  bus_b.i_axi_wdata = '0;  bus_b.i_axi_wstrb = '0;
    bus_b.i_axi_bready = 1'b1;  bus_b.i_axi_arvalid = 1'b0; bus_b.i_axi_araddr = '0;
    bus_b.i_axi_arprot = '0;    bus_b.i_axi_rready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", 32'(bus_a.o_wb_cyc), 32'd0);
    chk("rst_stb", 32'(bus_a.o_wb_stb), 32'd0);
    chk("rst_we", 32'(bus_a.o_wb_we), 32'd0);
    chk("rst_valids", 32'({bus_a.o_axi_bvalid, bus_a.o_axi_rvalid}), 32'd0);
    chk("rst_addr_sel", 32'({bus_a.o_wb_addr, bus_a.o_wb_sel}), 32'd0);
    chk("rst_data", bus_a.o_wb_data, 32'd0);
    chk("rst_rdata", bus_a.o_axi_rdata, 32'd0);
    chk("rst_resp", 32'({bus_a.o_axi_bresp, bus_a.o_axi_rresp}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin: both requests held, read-next after reset -> R W R W
    a_rdata = 32'hA5A5_0001;
    push(0, 1'b0, 2'b00, 32'hA5A5_0001);
    push(0, 1'b1, 2'b00, 32'h0);
    push(0, 1'b0, 2'b00, 32'hA5A5_0001);
    push(0, 1'b1, 2'b00, 32'h0);
    bus_a.i_axi_awaddr = 28'h40; bus_a.i_axi_wdata = 32'h1111_2222; bus_a.i_axi_wstrb = 4'hF;
    bus_a.i_axi_araddr = 28'h44;
    bus_a.i_axi_awvalid = 1'b1; bus_a.i_axi_wvalid = 1'b1; bus_a.i_axi_arvalid = 1'b1;
    order = ""; nr = 0; nw = 0; n = 0;
    while (nr + nw < 4 && n < 200) begin
      @(negedge clk); n++;
      if (bus_a.o_axi_arready) begin order = {order, "R"}; nr++; end
      if (bus_a.o_axi_awready) begin order = {order, "W"}; nw++; end
      @(posedge clk); #1;
      if (nr >= 2) bus_a.i_axi_arvalid = 1'b0;
      if (nw >= 2) begin bus_a.i_axi_awvalid = 1'b0; bus_a.i_axi_wvalid = 1'b0; end
    end
    bus_a.i_axi_arvalid = 1'b0; bus_a.i_axi_awvalid = 1'b0; bus_a.i_axi_wvalid = 1'b0;
    exp_order = "RWRW";
    chk("a_arb_count", 32'(order.len()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("a_arb_order", (i < order.len()) ? 32'(order[i]) : 32'd0, 32'(exp_order[i]));
    wait_sb(0);

    // Single write, ack one cycle after stb, latency check
    push(0, 1'b1, 2'b00, 32'h0);
    a_write(28'h10, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    chk("wr_stb", 32'(bus_a.o_wb_stb), 32'd1);
    chk("wr_addr", 32'(bus_a.o_wb_addr), 32'h4);
    chk("wr_we", 32'(bus_a.o_wb_we), 32'd1);
    chk("wr_sel", 32'(bus_a.o_wb_sel), 32'hF);
    chk("wr_data", bus_a.o_wb_data, 32'hDEAD_BEEF);
    ncnt = 1;
    while (!bus_a.o_axi_bvalid && ncnt < 20) begin @(negedge clk); ncnt++; end
    chk("wr_latency", 32'(ncnt), 32'd3);
    wait_sb(0);

    // Read with 2 stall cycles, response held while rready low
    a_stall_cfg = 2; a_rdata = 32'h1234_5678;
    bus_a.i_axi_rready = 1'b0;
    push(0, 1'b0, 2'b00, 32'h1234_5678);
    a_read(28'h20);
    ncnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("rd_addr", 32'(bus_a.o_wb_addr), 32'h8);
        chk("rd_we_sel", 32'({bus_a.o_wb_we, bus_a.o_wb_sel}), 32'h0F);
      end
      if (bus_a.o_wb_stb) ncnt++;
    end
    chk("rd_stb_cycles", 32'(ncnt), 32'd3);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!bus_a.o_axi_rvalid || bus_a.o_axi_rdata !== 32'h1234_5678 ||
          bus_a.o_axi_rresp !== 2'b00) ok = 1'b0;
    end
    chk("rd_hold_stable", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus_a.i_axi_rready = 1'b1; a_stall_cfg = 0;
    wait_sb(0);

    // Timeout: slave never acks a read
    a_noack = 1'b1;
    push(0, 1'b0, 2'b11, 32'h0);
    a_read(28'h30);
    ncnt = 0; n = 0;
    do begin
      @(negedge clk); n++;
      if (bus_a.o_wb_cyc) ncnt++;
    end while ((bus_a.o_wb_cyc || ncnt == 0) && n < 50);
    chk("to_cyc_cycles", 32'(ncnt), 32'd8);
    @(posedge clk); #1;
    a_noack = 1'b0;
    wait_sb(0);

    // WB err on a write
    a_err = 1'b1;
    push(0, 1'b1, 2'b10, 32'h0);
    a_write(28'h54, 32'hCAFE_F00D, 4'h3);
    @(negedge clk);
    chk("err_sel", 32'(bus_a.o_wb_sel), 32'h3);
    n = 0;
    while (!bus_a.i_wb_err && n < 20) begin @(negedge clk); n++; end
    chk("err_cyc_during", 32'(bus_a.o_wb_cyc), 32'd1);
    @(negedge clk);
    chk("err_cyc_drop", 32'(bus_a.o_wb_cyc), 32'd0);
    @(posedge clk); #1;
    a_err = 1'b0;
    wait_sb(0);

    // Reset while in WAIT: response dropped, then normal service
    a_noack = 1'b1;
    a_read(28'h64);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus_a.o_wb_cyc && !bus_a.o_wb_stb) && n < 20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a_noack = 1'b0;
    @(negedge clk);
    chk("rstw_cyc_stb", 32'({bus_a.o_wb_cyc, bus_a.o_wb_stb}), 32'd0);
    chk("rstw_valids", 32'({bus_a.o_axi_bvalid, bus_a.o_axi_rvalid}), 32'd0);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus_a.o_axi_bvalid || bus_a.o_axi_rvalid || bus_a.o_wb_cyc) ok = 1'b0;
    end
    chk("rstw_quiet", 32'(ok), 32'd1);
    @(posedge clk); #1;
    push(0, 1'b1, 2'b00, 32'h0);
    a_write(28'h70, 32'h0F0F_0F0F, 4'hF);
    @(negedge clk);
    chk("rstw_next_addr", 32'(bus_a.o_wb_addr), 32'h1C);
    wait_sb(0);
    a_rdata = 32'h55AA_55AA;
    push(0, 1'b0, 2'b00, 32'h55AA_55AA);
    a_read(28'h74);
    wait_sb(0);

    // dut_b: read-only write gets DECERR without a bus cycle
    push(1, 1'b1, 2'b11, 32'h0);
    bus_b.i_axi_awaddr = 28'h10; bus_b.i_axi_wdata = 32'h7777_8888; bus_b.i_axi_wstrb = 4'hF;
    bus_b.i_axi_awvalid = 1'b1; bus_b.i_axi_wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_b.o_axi_awready && n < 100);
    chk("b_ro_accept", 32'(bus_b.o_axi_awready), 32'd1);
    @(posedge clk); #1;
    bus_b.i_axi_awvalid = 1'b0; bus_b.i_axi_wvalid = 1'b0;
    wait_sb(1);
    chk("b_ro_no_cyc", 32'(b_cyc_seen), 32'd0);

    // dut_b: write priority while write held -> W W W then R
    push(1, 1'b1, 2'b11, 32'h0);
    push(1, 1'b1, 2'b11, 32'h0);
    push(1, 1'b1, 2'b11, 32'h0);
    push(1, 1'b0, 2'b00, 32'h0BAD_F00D);
    bus_b.i_axi_araddr = 28'h80;
    bus_b.i_axi_awvalid = 1'b1; bus_b.i_axi_wvalid = 1'b1; bus_b.i_axi_arvalid = 1'b1;
    order = ""; nr = 0; nw = 0; n = 0;
    while (nr + nw < 4 && n < 200) begin
      @(negedge clk); n++;
      if (bus_b.o_axi_arready) begin order = {order, "R"}; nr++; end
      if (bus_b.o_axi_awready) begin order = {order, "W"}; nw++; end
      @(posedge clk); #1;
      if (nr >= 1) bus_b.i_axi_arvalid = 1'b0;
      if (nw >= 3) begin bus_b.i_axi_awvalid = 1'b0; bus_b.i_axi_wvalid = 1'b0; end
    end
    bus_b.i_axi_arvalid = 1'b0; bus_b.i_axi_awvalid = 1'b0; bus_b.i_axi_wvalid = 1'b0;
    exp_order = "WWWR";
    chk("b_arb_count", 32'(order.len()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("b_arb_order", (i < order.len()) ? 32'(order[i]) : 32'd0, 32'(exp_order[i]));
    wait_sb(1);
    chk("b_read_used_wb", 32'(b_cyc_seen), 32'd1);

    chk("a_sb_empty", 32'(sb_a.size()), 32'd0);
    chk("b_sb_empty", 32'(sb_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
